// File: rtl/ucsbece154a_mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous memory (core m0, loader/debug m1).
// Latency: request sampled in IDLE at N -> gnt/mem access at N+1 -> read data + rvalid at N+2.
// Backpressure: no queueing; a master holds req/we/addr/wdata until it sees its gnt.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   m{0,1}_req_i/_we_i         access request and write flag per master
//   m{0,1}_addr_i/_wdata_i     byte address and write data per master
//   m{0,1}_gnt_o               one-cycle accept pulse (ACCESS)
//   m{0,1}_rvalid_o            one-cycle read-data-valid pulse (RESP)
//   rdata_o                    shared read data, holds last response
//   mem_en_o/_we_o/_addr_o/_wdata_o, mem_rdata_i   memory side
//   busy_o                     high whenever a transaction is in flight
module ucsbece154a_mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  output logic        m0_rvalid_o,
  output logic        m1_rvalid_o,
  output logic [31:0] rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Latched winner request.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 0 = m0, 1 = m1
  logic        win_id_q, win_id_d;
  acc_t        acc_q, acc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        pick_m1;
  logic        gnt0, gnt1, rv0, rv1, en;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_id_d     = win_id_q;
    acc_d        = acc_q;
    rdata_d      = rdata_q;
    pick_m1      = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    rv0          = 1'b0;
    rv1          = 1'b0;
    en           = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          // On a tie, round-robin favours whoever did not win last time.
          if (m0_req_i && m1_req_i) pick_m1 = RR_EN ? !last_grant_q : 1'b0;
          else                      pick_m1 = m1_req_i;
          win_id_d     = pick_m1;
          last_grant_d = pick_m1;
          acc_d        = pick_m1 ? acc_t'({m1_we_i, m1_addr_i, m1_wdata_i})
                                 : acc_t'({m0_we_i, m0_addr_i, m0_wdata_i});
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        en      = 1'b1;
        gnt0    = !win_id_q;
        gnt1    = win_id_q;
        state_d = acc_q.we ? IDLE : RESP;
      end
      RESP: begin
        rv0     = !win_id_q;
        rv1     = win_id_q;
        rdata_d = mem_rdata_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      win_id_q     <= 1'b0;
      acc_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_id_q     <= win_id_d;
      acc_q        <= acc_d;
      rdata_q      <= rdata_d;
    end
  end

  // Outputs are forced quiet while reset is high so an in-flight transaction
  // is dropped immediately rather than one cycle later.
  assign m0_gnt_o    = gnt0 & ~reset;
  assign m1_gnt_o    = gnt1 & ~reset;
  assign m0_rvalid_o = rv0 & ~reset;
  assign m1_rvalid_o = rv1 & ~reset;
  assign mem_en_o    = en & ~reset;
  assign mem_we_o    = en & acc_q.we & ~reset;
  assign mem_addr_o  = reset ? 32'd0 : acc_q.addr;
  assign mem_wdata_o = reset ? 32'd0 : acc_q.wdata;
  assign rdata_o     = reset ? 32'd0 : ((state_q == RESP) ? mem_rdata_i : rdata_q);
  assign busy_o      = ~reset & (state_q != IDLE);

endmodule

// File: doc/ucsbece154a_mem_arbiter.md
UCSBECE154A_MEM_ARBITER -- requirements
Module: ucsbece154a_mem_arbiter

Interface
REQ-001 Parameter: RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with m0 highest.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: m0_req_i, m1_req_i  input  1 each  access request from the core (m0) or the loader/debug port (m1).
REQ-005 Port: m0_we_i, m1_we_i  input  1 each  1 = write, 0 = read.
REQ-006 Port: m0_addr_i, m1_addr_i  input  32 each  byte address.
REQ-007 Port: m0_wdata_i, m1_wdata_i  input  32 each  write data.
REQ-008 Port: m0_gnt_o, m1_gnt_o  output  1 each  request accepted; pulses for one cycle during ACCESS.
REQ-009 Port: m0_rvalid_o, m1_rvalid_o  output  1 each  read data valid on rdata_o; pulses for one cycle during RESP.
REQ-010 Port: rdata_o  output  32  read data, shared by both masters.
REQ-011 Port: mem_en_o, mem_we_o  output  1 each  memory enable and write enable.
REQ-012 Port: mem_addr_o, mem_wdata_o  output  32 each  memory address and write data.
REQ-013 Port: mem_rdata_i  input  32  synchronous memory read data, valid the cycle after a read enable.
REQ-014 Port: busy_o  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-016 In IDLE with no request, the block SHALL stay in IDLE with all gnt, rvalid and mem_en outputs at 0.
REQ-017 In IDLE with at least one request, the block SHALL choose a winner and latch the winner's we, addr and wdata plus a winner ID; the next state SHALL be ACCESS.
REQ-018 If only one request is present, that master SHALL win.
REQ-019 If both requests are present and RR_EN=1, the master not recorded in last_grant SHALL win; if RR_EN=0, m0 SHALL win.
REQ-020 last_grant SHALL update to the winner ID on entry to ACCESS.
REQ-021 In ACCESS: mem_en_o=1; mem_we_o, mem_addr_o and mem_wdata_o SHALL equal the latched values; the winner's gnt_o SHALL be 1 for exactly this one cycle.
REQ-022 From ACCESS, a write SHALL go to IDLE and a read SHALL go to RESP.
REQ-023 In RESP: rdata_o = mem_rdata_i; the winner's rvalid_o SHALL be 1 for one cycle; next state SHALL be IDLE.
REQ-024 Latency from request sampled in IDLE at cycle N: gnt in cycle N+1; read data in cycle N+2; the next arbitration SHALL occur at N+2 for a write and N+3 for a read.
REQ-025 Request inputs SHALL be sampled only in IDLE; changes during ACCESS or RESP SHALL have no effect, and a request dropped before its IDLE sample SHALL be ignored.
REQ-026 Each master SHALL hold req, we, addr and wdata stable until it sees its gnt; gnt and rvalid SHALL never be asserted to both masters in the same cycle.
REQ-027 Outside ACCESS: mem_en_o=0, mem_we_o=0, and mem_addr_o/mem_wdata_o SHALL hold the latched values.
REQ-028 Outside RESP, rdata_o SHALL hold its last driven value; rdata_o is 0 after reset.
REQ-029 A master that holds req high continuously SHALL be granted within 2 arbitrations when RR_EN=1 (no starvation).

Reset
REQ-030 While reset is high at a clock edge, the next state SHALL be IDLE and last_grant SHALL be 1 (m1), so m0 wins the first tie.
REQ-031 During reset, all gnt, rvalid, mem_en, mem_we and busy outputs SHALL be 0, and the latched addr, wdata and rdata SHALL be 0.
REQ-032 Reset asserted in ACCESS or RESP SHALL abort the transaction: no gnt or rvalid in the following cycle, and no retry afterwards.

Verification
REQ-033 m0 alone reads 0x0000_0010 while mem returns 0xDEAD_BEEF -> m0_gnt_o in cycle N+1 with mem_addr_o=0x10 and mem_we_o=0; m0_rvalid_o with rdata_o=0xDEADBEEF in cycle N+2.
REQ-034 m1 alone writes 0x1234_5678 to 0x20 -> mem_en_o=1, mem_we_o=1, mem_wdata_o=0x12345678 and m1_gnt_o in cycle N+1; no rvalid; busy_o low at N+2.
REQ-035 Both masters hold reads continuously with RR_EN=1 after reset -> grants alternate m0, m1, m0, m1, each 3 cycles apart.
REQ-036 Same stimulus as REQ-035 with RR_EN=0 -> m0 is granted every time and m1 is never granted.
REQ-037 Reset asserted during the ACCESS cycle of an m1 read -> no m1_rvalid_o; IDLE next cycle; the next tie goes to m0.
REQ-038 m0 read with req dropped after gnt while m1 requests during RESP -> m0_rvalid_o issues normally; m1 is granted at the following IDLE sample.
